// File: rtl/sid_voice_gen_if.sv
// Combined-waveform LUT bus between one SID voice and its lookup tables.
// The voice drives the two addresses; the tables return data LUT_LAT clocks later.
interface sid_voice_gen_if #(
    parameter int WAVE_W = 12,
    parameter int LUT_W  = 8
);
    logic [WAVE_W-1:0] lut_addr_saw;
    logic [WAVE_W-1:0] lut_addr_tri;
    logic [LUT_W-1:0]  lut_st;
    logic [LUT_W-1:0]  lut_pt;
    logic [LUT_W-1:0]  lut_ps;
    logic [LUT_W-1:0]  lut_pst;

    modport master (
        output lut_addr_saw, lut_addr_tri,
        input  lut_st, lut_pt, lut_ps, lut_pst
    );
    modport slave (
        input  lut_addr_saw, lut_addr_tri,
        output lut_st, lut_pt, lut_ps, lut_pst
    );
endinterface

// File: rtl/sid_voice_gen.sv
// SID voice generator: tick-gated phase accumulator and noise LFSR, waveform
// generation, LUT-latency alignment, waveform select and envelope (DCA) multiply.
// Every tick launches one sample down a fixed-latency pipe (LUT_LAT+4 clocks).
module sid_voice_gen #(
    parameter int ACC_W     = 24,
    parameter int FREQ_W    = 16,
    parameter int WAVE_W    = 12,
    parameter int ENV_W     = 8,
    parameter int LUT_W     = 8,
    parameter int LUT_LAT   = 2,
    parameter int LFSR_W    = 23,
    parameter int NOISE_BIT = 19
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tick,
    input  logic [FREQ_W-1:0] freq,
    input  logic [WAVE_W-1:0] pw,
    input  logic [7:0]        control,
    input  logic [ENV_W-1:0]  env,
    input  logic              osc_msb_in,
    sid_voice_gen_if.master   lut,
    output logic              osc_msb_out,
    output logic [WAVE_W-1:0] saw_out,
    output logic [WAVE_W-1:0] tri_out,
    output logic [7:0]        osc_out,
    output logic [WAVE_W-1:0] sample_out,
    output logic              sample_valid
);
    localparam int STAGES = LUT_LAT + 4;
    localparam int PROD_W = WAVE_W + ENV_W;

    typedef struct packed {
        logic [WAVE_W-1:0] saw;
        logic [WAVE_W-1:0] tri_w;
        logic [WAVE_W-1:0] pulse;
        logic [WAVE_W-1:0] noise;
    } waves_t;

    logic [ACC_W-1:0]  acc, acc_nxt;
    logic [LFSR_W-1:0] lfsr, lfsr_nxt;
    logic              msb_prv;
    logic [STAGES:1]   vld_pipe;
    waves_t            s1_c, s1_q, s2;
    waves_t [LUT_LAT-1:0] dly;
    logic              ring_m;
    logic [WAVE_W-1:0] wave_c, wave_s3, mix_c;
    logic [WAVE_W-1:0] st_w, pt_w, ps_w, pst_w;
    logic [PROD_W-1:0] prod;
    logic [WAVE_W-1:0] sample_q;
    logic              unused_gate;

    assign unused_gate = control[0];

    // S0 next state: test and sync clear the phase, accumulator bit edge clocks the LFSR
    always_comb begin
        acc_nxt  = acc + ACC_W'(freq);
        lfsr_nxt = lfsr;
        if (control[3] || (control[1] && msb_prv && !osc_msb_in))
            acc_nxt = '0;
        if (control[3])
            lfsr_nxt = '1;
        else if (acc_nxt[NOISE_BIT] && !acc[NOISE_BIT])
            lfsr_nxt = {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[LFSR_W-6]};
    end

    // S0 state: only advances on a sample tick
    always_ff @(posedge clock) begin
        if (reset) begin
            acc     <= '0;
            lfsr    <= '1;
            msb_prv <= 1'b0;
        end else if (tick) begin
            acc     <= acc_nxt;
            lfsr    <= lfsr_nxt;
            msb_prv <= osc_msb_in;
        end
    end

    // Sample-valid shift register; reset flushes everything in flight
    always_ff @(posedge clock) begin
        if (reset) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[STAGES-1:1], tick};
    end

    // S1 raw waveforms from the freshly updated accumulator
    always_comb begin
        ring_m      = acc[ACC_W-1] ^ (control[2] & osc_msb_in);
        s1_c.saw    = acc[ACC_W-1 -: WAVE_W];
        s1_c.tri_w  = {acc[ACC_W-2 -: WAVE_W-1] ^ {(WAVE_W-1){ring_m}}, 1'b0};
        s1_c.pulse  = (control[3] || (s1_c.saw >= pw)) ? '1 : '0;
        s1_c.noise  = WAVE_W'({lfsr[21], lfsr[19], lfsr[15], lfsr[12],
                               lfsr[10], lfsr[6],  lfsr[3],  lfsr[1]}) << (WAVE_W - 8);
    end

    // S1 register; its saw/tri also serve as the LUT addresses
    always_ff @(posedge clock) begin
        if (reset)            s1_q <= '0;
        else if (vld_pipe[1]) s1_q <= s1_c;
    end

    assign lut.lut_addr_saw = s1_q.saw;
    assign lut.lut_addr_tri = s1_q.tri_w;
    assign saw_out          = s1_q.saw;
    assign tri_out          = s1_q.tri_w;
    assign osc_msb_out      = acc[ACC_W-1];

    // S2 free-running delay so the raw waves line up with LUT data
    always_ff @(posedge clock) begin
        if (reset) begin
            dly <= '0;
        end else begin
            dly[0] <= s1_q;
            for (int i = 1; i < LUT_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    assign s2    = dly[LUT_LAT-1];
    assign st_w  = WAVE_W'(lut.lut_st)  << (WAVE_W - LUT_W);
    assign pt_w  = WAVE_W'(lut.lut_pt)  << (WAVE_W - LUT_W);
    assign ps_w  = WAVE_W'(lut.lut_ps)  << (WAVE_W - LUT_W);
    assign pst_w = WAVE_W'(lut.lut_pst) << (WAVE_W - LUT_W);

    // S3 waveform select; noise combos AND noise with the OR of the other raw waves
    always_comb begin
        mix_c = (control[4] ? s2.tri_w : '0) | (control[5] ? s2.saw : '0) |
                (control[6] ? s2.pulse : '0);
        case (control[7:4])
            4'b0000: wave_c = '0;
            4'b0001: wave_c = s2.tri_w;
            4'b0010: wave_c = s2.saw;
            4'b0011: wave_c = st_w;
            4'b0100: wave_c = s2.pulse;
            4'b0101: wave_c = pt_w & s2.pulse;
            4'b0110: wave_c = ps_w & s2.pulse;
            4'b0111: wave_c = pst_w & s2.pulse;
            4'b1000: wave_c = s2.noise;
            default: wave_c = s2.noise & mix_c;
        endcase
    end

    // S3 register
    always_ff @(posedge clock) begin
        if (reset)                    wave_s3 <= '0;
        else if (vld_pipe[LUT_LAT+2]) wave_s3 <= wave_c;
    end

    assign osc_out = wave_s3[WAVE_W-1 -: 8];
    assign prod    = PROD_W'(wave_s3) * PROD_W'(env);

    // S4 DCA: keep the top WAVE_W bits of the full product
    always_ff @(posedge clock) begin
        if (reset)                    sample_q <= '0;
        else if (vld_pipe[STAGES-1]) sample_q <= prod[PROD_W-1 -: WAVE_W];
    end

    assign sample_out   = sample_q;
    assign sample_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_sid_voice_gen.sv
// Bench for sid_voice_gen: random and directed ticks, a behavioural voice model,
// and a negedge monitor that checks samples, their latency and S1 outputs.
module tb_sid_voice_gen;
    localparam int LUT_LAT = 2;
    localparam int LAT     = LUT_LAT + 4;

    logic        clock = 1'b0, reset = 1'b1, tick = 1'b0, osc_msb_in = 1'b0;
    logic [15:0] freq = '0;
    logic [11:0] pw = '0;
    logic [7:0]  control = '0, env = '0;
    logic        osc_msb_out, sample_valid;
    logic [11:0] saw_out, tri_out, sample_out;
    logic [7:0]  osc_out;

    sid_voice_gen_if #(.WAVE_W(12), .LUT_W(8)) lut_bus ();

    sid_voice_gen #(.LUT_LAT(LUT_LAT)) dut (
        .clock(clock), .reset(reset), .tick(tick), .freq(freq), .pw(pw),
        .control(control), .env(env), .osc_msb_in(osc_msb_in), .lut(lut_bus.master),
        .osc_msb_out(osc_msb_out), .saw_out(saw_out), .tri_out(tri_out),
        .osc_out(osc_out), .sample_out(sample_out), .sample_valid(sample_valid)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Arbitrary table contents: 0 = _st, 1 = p_t, 2 = ps_, 3 = pst
    function automatic logic [7:0] lut_f(input int k, input logic [11:0] a);
        case (k)
            0:       return a[11:4] ^ {a[3:0], a[7:4]};
            1:       return a[11:4] + 8'h35;
            2:       return a[10:3] & 8'hB7;
            default: return a[11:4] | {a[1:0], 6'h00};
        endcase
    endfunction

    logic [LUT_LAT-1:0][7:0] p_st, p_pt, p_ps, p_pst;
    always @(posedge clock) begin
        for (int i = LUT_LAT - 1; i > 0; i--) begin
            p_st[i] <= p_st[i-1]; p_pt[i] <= p_pt[i-1];
            p_ps[i] <= p_ps[i-1]; p_pst[i] <= p_pst[i-1];
        end
        p_st[0]  <= lut_f(0, lut_bus.lut_addr_saw);
        p_pt[0]  <= lut_f(1, lut_bus.lut_addr_tri);
        p_ps[0]  <= lut_f(2, lut_bus.lut_addr_saw);
        p_pst[0] <= lut_f(3, lut_bus.lut_addr_saw);
    end
    assign lut_bus.lut_st  = p_st[LUT_LAT-1];
    assign lut_bus.lut_pt  = p_pt[LUT_LAT-1];
    assign lut_bus.lut_ps  = p_ps[LUT_LAT-1];
    assign lut_bus.lut_pst = p_pst[LUT_LAT-1];

    typedef struct { int due; logic [11:0] smp; } exp_t;
    typedef struct { int due; logic [11:0] saw; logic [11:0] tw; } s1_t;
    exp_t sb_q[$];
    s1_t  s1_q[$];
    exp_t mon_e;
    s1_t  mon_s;
    int   n_chk = 0, n_err = 0;

    logic [23:0] m_acc  = '0;
    logic [22:0] m_lfsr = '1;
    logic        m_prv  = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Issue one tick at a negedge, update the model, queue the expected results
    task automatic do_tick(input logic [15:0] f, input int gap);
        logic [23:0] nacc;
        logic [11:0] saw, tw, pul, noi, nn, wave;
        logic        m;
        int          prod;
        freq = f;
        tick = 1'b1;
        if (control[3] || (control[1] && m_prv && !osc_msb_in)) nacc = '0;
        else nacc = m_acc + {8'h00, f};
        if (control[3]) m_lfsr = '1;
        else if (!m_acc[19] && nacc[19]) m_lfsr = {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[17]};
        m_prv = osc_msb_in;
        m_acc = nacc;
        saw  = nacc[23:12];
        m    = nacc[23] ^ (control[2] & osc_msb_in);
        tw   = {nacc[22:12] ^ {11{m}}, 1'b0};
        pul  = (control[3] || saw >= pw) ? 12'hFFF : 12'h000;
        noi  = {m_lfsr[21], m_lfsr[19], m_lfsr[15], m_lfsr[12],
                m_lfsr[10], m_lfsr[6], m_lfsr[3], m_lfsr[1], 4'h0};
        nn   = (control[4] ? tw : 12'h0) | (control[5] ? saw : 12'h0) | (control[6] ? pul : 12'h0);
        case (control[7:4])
            4'h0:    wave = 12'h000;
            4'h1:    wave = tw;
            4'h2:    wave = saw;
            4'h3:    wave = {lut_f(0, saw), 4'h0};
            4'h4:    wave = pul;
            4'h5:    wave = {lut_f(1, tw), 4'h0} & pul;
            4'h6:    wave = {lut_f(2, saw), 4'h0} & pul;
            4'h7:    wave = {lut_f(3, saw), 4'h0} & pul;
            4'h8:    wave = noi;
            default: wave = noi & nn;
        endcase
        prod = int'(wave) * int'(env);
        sb_q.push_back('{cyc + LAT, 12'(prod >> 8)});
        s1_q.push_back('{cyc + 2, saw, tw});
        @(negedge clock);
        tick = 1'b0;
        chk("osc_msb_out", osc_msb_out, nacc[23]);
        repeat (gap - 1) @(negedge clock);
    endtask

    task automatic drain();
        repeat (LAT + 2) @(negedge clock);
    endtask

    // Monitor: pops expectations whenever the DUT presents a sample or an S1 result is due
    always @(negedge clock) begin
        if (sample_valid === 1'b1) begin
            if (sb_q.size() == 0) chk("unexpected sample_valid", sample_valid, 1'b0);
            else begin
                mon_e = sb_q.pop_front();
                chk("sample_out", sample_out, mon_e.smp);
                chk("sample latency", cyc, mon_e.due);
            end
        end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            mon_e = sb_q.pop_front();
            chk("sample_valid at due cycle", sample_valid, 1'b1);
        end
        if (s1_q.size() > 0 && s1_q[0].due <= cyc) begin
            mon_s = s1_q.pop_front();
            chk("saw_out", saw_out, mon_s.saw);
            chk("tri_out", tri_out, mon_s.tw);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, %0d expectations pending", sb_q.size());
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clock);
        chk("reset sample_out", sample_out, 12'h000);
        chk("reset sample_valid", sample_valid, 1'b0);
        chk("reset saw_out", saw_out, 12'h000);
        chk("reset tri_out", tri_out, 12'h000);
        chk("reset osc_out", osc_out, 8'h00);
        chk("reset osc_msb_out", osc_msb_out, 1'b0);
        chk("reset lut_addr_saw", lut_bus.lut_addr_saw, 12'h000);
        reset = 1'b0;

        // Saw, back-to-back ticks
        control = 8'h20; env = 8'hFF; pw = 12'h000;
        repeat (16) do_tick(16'h1000, 1);
        drain();
        chk("saw after 16 ticks", saw_out, 12'h010);

        // Max frequency through the _st LUT, sparse ticks, wrap-around
        control = 8'h30; env = 8'hC3;
        repeat (257) do_tick(16'hFFFF, 4);
        drain();

        // Pulse against pw, then test forces full-scale pulse and clears the phase
        control = 8'h40; pw = 12'h800; env = 8'hFF;
        repeat (64) do_tick(16'(($urandom_range(16'h0800, 16'h4000))), $urandom_range(1, 3));
        drain();
        control = 8'h48;
        do_tick(16'h1234, 1);
        do_tick(16'h0777, 1);
        drain();
        chk("pulse with test", sample_out, 12'hFEF);
        chk("test clears phase", saw_out, 12'h000);

        // Hard sync on a falling modulator MSB, then the same edge with sync off
        control = 8'h22; env = 8'h80;
        osc_msb_in = 1'b1; do_tick(16'h1234, 2); do_tick(16'h1234, 2);
        osc_msb_in = 1'b0; do_tick(16'h1234, 2);
        drain();
        chk("sync clears phase", saw_out, 12'h000);
        control = 8'h20;
        osc_msb_in = 1'b1; do_tick(16'h1234, 2); do_tick(16'h1234, 2);
        osc_msb_in = 1'b0; do_tick(16'h1234, 2);
        drain();
        chk("no sync when disabled", saw_out, 12'h003);

        // Ring modulation on a zero phase
        control = 8'h1C; osc_msb_in = 1'b1;
        do_tick(16'h0000, 1);
        drain();
        chk("ringmod tri msb_in=1", tri_out, 12'hFFE);
        control = 8'h14; osc_msb_in = 1'b0;
        do_tick(16'h0000, 1);
        drain();
        chk("ringmod tri msb_in=0", tri_out, 12'h000);

        // Noise: LFSR stepping, test reload, more stepping
        control = 8'h80; env = 8'hFF;
        repeat (512) do_tick(16'h1000, 1);
        drain();
        control = 8'h88;
        do_tick(16'h1000, 1);
        drain();
        control = 8'h80;
        repeat (64) do_tick(16'hC35B, 1);
        drain();

        // Random selects (including all LUT and noise combinations), pw, env, sync
        repeat (24) begin
            control = {4'($urandom_range(0, 15)), 2'b00, 1'($urandom_range(0, 1)), 1'b0};
            pw = 12'($urandom); env = 8'($urandom);
            freq = 16'($urandom);
            for (int i = 0; i < 20; i++) begin
                osc_msb_in = 1'($urandom_range(0, 1));
                do_tick(freq, $urandom_range(1, 3));
            end
            drain();
        end

        // Reset with a sample in flight: it must never appear
        control = 8'h20; osc_msb_in = 1'b0; env = 8'hFF;
        do_tick(16'h1000, 1);
        @(negedge clock);
        reset = 1'b1;
        sb_q.delete();
        s1_q.delete();
        m_acc = '0; m_lfsr = '1; m_prv = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("mid reset sample_out", sample_out, 12'h000);
        chk("mid reset saw_out", saw_out, 12'h000);
        repeat (12) @(negedge clock);
        do_tick(16'h0777, 1);
        drain();

        chk("pending expectations", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
